// File: rtl/dest_ip_filter_reg_ctrl.sv
// Host register window onto the destination-IP filter table: ENTRY_IP, RD_ADDR,
// WR_ADDR and STATUS turn host accesses into single-pulse table read/write requests.
module dest_ip_filter_reg_ctrl #(
  parameter int unsigned LUT_DEPTH      = 32,
  parameter int unsigned LUT_DEPTH_BITS = 5,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reg_req,
  input  logic                      reg_rd_wr_L,
  input  logic [1:0]                reg_addr,
  input  logic [31:0]               reg_wr_data,
  output logic                      reg_ack,
  output logic [31:0]               reg_rd_data,
  output logic [LUT_DEPTH_BITS-1:0] dest_ip_filter_rd_addr,
  output logic                      dest_ip_filter_rd_req,
  input  logic [31:0]               dest_ip_filter_rd_ip,
  input  logic                      dest_ip_filter_rd_ack,
  output logic [LUT_DEPTH_BITS-1:0] dest_ip_filter_wr_addr,
  output logic                      dest_ip_filter_wr_req,
  output logic [31:0]               dest_ip_filter_wr_ip,
  input  logic                      dest_ip_filter_wr_ack
);

  if (LUT_DEPTH == 0 || LUT_DEPTH > (1 << LUT_DEPTH_BITS)) begin : g_bad_depth
    $error("LUT_DEPTH must be 1..2**LUT_DEPTH_BITS");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_WAIT,
    RD_ISSUE,
    RD_WAIT,
    DONE
  } state_t;

  localparam logic [1:0]  ADDR_ENTRY_IP = 2'd0;
  localparam logic [1:0]  ADDR_RD_ADDR  = 2'd1;
  localparam logic [1:0]  ADDR_WR_ADDR  = 2'd2;
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state;
  logic [31:0] entry_ip;
  logic        timed_out;
  logic        overrun;
  logic [15:0] timeout_count;
  logic [15:0] wait_count;
  logic [31:0] status_word;
  logic [31:0] read_mux;

  // The index registers double as the table address outputs, and ENTRY_IP as
  // the write data, so they are stable for the whole operation by construction.
  assign dest_ip_filter_wr_ip = entry_ip;
  assign status_word = {timeout_count, 13'd0, overrun, timed_out, state != IDLE};

  always_comb begin
    read_mux = '0;
    case (reg_addr)
      ADDR_ENTRY_IP: read_mux = entry_ip;
      ADDR_RD_ADDR:  read_mux = 32'(dest_ip_filter_rd_addr);
      ADDR_WR_ADDR:  read_mux = 32'(dest_ip_filter_wr_addr);
      default:       read_mux = status_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= IDLE;
      entry_ip               <= '0;
      timed_out              <= 1'b0;
      overrun                <= 1'b0;
      timeout_count          <= '0;
      wait_count             <= '0;
      reg_ack                <= 1'b0;
      reg_rd_data            <= '0;
      dest_ip_filter_rd_addr <= '0;
      dest_ip_filter_rd_req  <= 1'b0;
      dest_ip_filter_wr_addr <= '0;
      dest_ip_filter_wr_req  <= 1'b0;
    end else begin
      reg_ack               <= 1'b0;
      reg_rd_data           <= '0;
      dest_ip_filter_rd_req <= 1'b0;
      dest_ip_filter_wr_req <= 1'b0;

      if (reg_req && state != IDLE) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (reg_req) begin
            if (reg_rd_wr_L) begin
              reg_ack     <= 1'b1;
              reg_rd_data <= read_mux;
            end else begin
              case (reg_addr)
                ADDR_ENTRY_IP: begin
                  entry_ip <= reg_wr_data;
                  reg_ack  <= 1'b1;
                end
                ADDR_RD_ADDR: begin
                  dest_ip_filter_rd_addr <= reg_wr_data[LUT_DEPTH_BITS-1:0];
                  dest_ip_filter_rd_req  <= 1'b1;
                  state                  <= RD_ISSUE;
                end
                ADDR_WR_ADDR: begin
                  dest_ip_filter_wr_addr <= reg_wr_data[LUT_DEPTH_BITS-1:0];
                  dest_ip_filter_wr_req  <= 1'b1;
                  state                  <= WR_ISSUE;
                end
                default: begin
                  timed_out     <= 1'b0;
                  overrun       <= 1'b0;
                  timeout_count <= '0;
                  reg_ack       <= 1'b1;
                end
              endcase
            end
          end
        end

        WR_ISSUE: begin
          wait_count <= 16'd1;
          state      <= WR_WAIT;
        end

        RD_ISSUE: begin
          wait_count <= 16'd1;
          state      <= RD_WAIT;
        end

        WR_WAIT, RD_WAIT: begin
          // Ack is tested before the limit so a same-cycle ack counts as success.
          if ((state == WR_WAIT && dest_ip_filter_wr_ack) ||
              (state == RD_WAIT && dest_ip_filter_rd_ack)) begin
            if (state == RD_WAIT) begin
              entry_ip <= dest_ip_filter_rd_ip;
            end
            timed_out <= 1'b0;
            reg_ack   <= 1'b1;
            state     <= DONE;
          end else if (wait_count >= TIMEOUT_LIMIT) begin
            timed_out <= 1'b1;
            if (timeout_count != 16'hFFFF) begin
              timeout_count <= timeout_count + 16'd1;
            end
            reg_ack <= 1'b1;
            state   <= DONE;
          end else begin
            wait_count <= wait_count + 16'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dest_ip_filter_reg_ctrl.sv
// Bench for dest_ip_filter_reg_ctrl: host accesses and table requests are
// predicted into queues and matched against what the controller produces.
module tb_dest_ip_filter_reg_ctrl;

  localparam int unsigned DEPTH_BITS = 5;
  localparam int          TIMEOUT    = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  reg_req;
  logic                  reg_rd_wr_L;
  logic [1:0]            reg_addr;
  logic [31:0]           reg_wr_data;
  logic                  reg_ack;
  logic [31:0]           reg_rd_data;
  logic [DEPTH_BITS-1:0] rd_addr;
  logic                  rd_req;
  logic [31:0]           rd_ip;
  logic                  rd_ack;
  logic [DEPTH_BITS-1:0] wr_addr;
  logic                  wr_req;
  logic [31:0]           wr_ip;
  logic                  wr_ack;

  dest_ip_filter_reg_ctrl #(
    .LUT_DEPTH      (32),
    .LUT_DEPTH_BITS (DEPTH_BITS),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .reg_req                (reg_req),
    .reg_rd_wr_L            (reg_rd_wr_L),
    .reg_addr               (reg_addr),
    .reg_wr_data            (reg_wr_data),
    .reg_ack                (reg_ack),
    .reg_rd_data            (reg_rd_data),
    .dest_ip_filter_rd_addr (rd_addr),
    .dest_ip_filter_rd_req  (rd_req),
    .dest_ip_filter_rd_ip   (rd_ip),
    .dest_ip_filter_rd_ack  (rd_ack),
    .dest_ip_filter_wr_addr (wr_addr),
    .dest_ip_filter_wr_req  (wr_req),
    .dest_ip_filter_wr_ip   (wr_ip),
    .dest_ip_filter_wr_ack  (wr_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cycle;
    logic [31:0] data;
  } ack_exp_t;

  typedef struct {
    int          cycle;
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] ip;
  } req_exp_t;

  ack_exp_t ack_q[$];
  req_exp_t req_q[$];
  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Outputs are registered on posedge, so sampling on negedge is race-free.
  task automatic monitor();
    ack_exp_t ae;
    req_exp_t re;
    forever begin
      @(negedge clk);
      if (reg_ack) begin
        if (ack_q.size() == 0) begin
          check("unexpected_ack", 32'(reg_ack), 32'd0);
        end else begin
          ae = ack_q.pop_front();
          check("ack_cycle", 32'(cyc), 32'(ae.cycle));
          check("ack_data", reg_rd_data, ae.data);
        end
      end
      if (rd_req || wr_req) begin
        if (req_q.size() == 0) begin
          check("unexpected_req", 32'({rd_req, wr_req}), 32'd0);
        end else begin
          re = req_q.pop_front();
          check("req_cycle", 32'(cyc), 32'(re.cycle));
          check("req_type", 32'({rd_req, wr_req}), re.is_write ? 32'd1 : 32'd2);
          check("req_addr", re.is_write ? 32'(wr_addr) : 32'(rd_addr), re.addr);
          if (re.is_write) check("req_wr_ip", wr_ip, re.ip);
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host(input logic rd, input logic [1:0] addr, input logic [31:0] data);
    reg_req     = 1'b1;
    reg_rd_wr_L = rd;
    reg_addr    = addr;
    reg_wr_data = data;
    @(negedge clk);
    reg_req     = 1'b0;
    reg_rd_wr_L = 1'($urandom_range(0, 1));
    reg_addr    = 2'($urandom);
    reg_wr_data = $urandom;
  endtask

  task automatic reg_read(input logic [1:0] addr, input logic [31:0] exp);
    ack_q.push_back('{cycle: cyc + 1, data: exp});
    host(1'b1, addr, $urandom);
  endtask

  task automatic reg_write(input logic [1:0] addr, input logic [31:0] data);
    ack_q.push_back('{cycle: cyc + 1, data: 32'd0});
    host(1'b0, addr, data);
  endtask

  task automatic start_op(input logic is_write, input logic [31:0] data,
                          input logic [31:0] idx, input logic [31:0] ip);
    req_q.push_back('{cycle: cyc + 1, is_write: is_write, addr: idx, ip: ip});
    host(1'b0, is_write ? 2'd2 : 2'd1, data);
  endtask

  // Ack in the current cycle; leaves the bench in the cycle after DONE.
  task automatic table_ack(input logic is_write, input logic [31:0] ip);
    ack_q.push_back('{cycle: cyc + 1, data: 32'd0});
    if (is_write) begin
      wr_ack = 1'b1;
    end else begin
      rd_ack = 1'b1;
      rd_ip  = ip;
    end
    @(negedge clk);
    wr_ack = 1'b0;
    rd_ack = 1'b0;
    rd_ip  = $urandom;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;
    int          r;
    reset       = 1'b1;
    reg_req     = 1'b0;
    reg_rd_wr_L = 1'b0;
    reg_addr    = 2'd0;
    reg_wr_data = '0;
    rd_ip       = '0;
    rd_ack      = 1'b0;
    wr_ack      = 1'b0;
    fork
      monitor();
    join_none

    tick(3);
    check("rst_reg_ack", 32'(reg_ack), 32'd0);
    check("rst_rd_data", reg_rd_data, 32'd0);
    check("rst_reqs", 32'({rd_req, wr_req}), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_ip", wr_ip, 32'd0);
    reset = 1'b0;
    tick(1);

    // Table write with ack 4 cycles after the request.
    reg_write(2'd0, 32'hC0A8_0001);
    reg_read(2'd0, 32'hC0A8_0001);
    start_op(1'b1, 32'd3, 32'd3, 32'hC0A8_0001);
    tick(4);
    check("wr_addr_hold", 32'(wr_addr), 32'd3);
    check("wr_ip_hold", wr_ip, 32'hC0A8_0001);
    table_ack(1'b1, 32'd0);
    reg_read(2'd3, 32'd0);

    // Table read loads ENTRY_IP; stray acks in IDLE are ignored.
    start_op(1'b0, 32'd7, 32'd7, 32'd0);
    tick(2);
    table_ack(1'b0, 32'h0A00_0005);
    reg_read(2'd0, 32'h0A00_0005);
    rd_ack = 1'b1;
    rd_ip  = 32'hDEAD_BEEF;
    wr_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    wr_ack = 1'b0;
    reg_read(2'd0, 32'h0A00_0005);
    reg_read(2'd1, 32'd7);

    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      reg_write(2'd0, v);
      reg_read(2'd0, v);
    end

    // Timeout with a wrong-type ack mid-wait, then a late write ack.
    start_op(1'b1, 32'd1, 32'd1, v);
    r = cyc;
    ack_q.push_back('{cycle: r + TIMEOUT + 1, data: 32'd0});
    tick(3);
    rd_ack = 1'b1;
    rd_ip  = 32'hFFFF_FFFF;
    tick(1);
    rd_ack = 1'b0;
    tick(TIMEOUT - 2);
    wr_ack = 1'b1;
    tick(1);
    wr_ack = 1'b0;
    reg_read(2'd3, 32'h0001_0002);
    reg_read(2'd0, v);

    // Ack on the timeout cycle itself is a success and clears the timeout flag.
    start_op(1'b1, 32'd4, 32'd4, v);
    tick(TIMEOUT);
    table_ack(1'b1, 32'd0);
    reg_read(2'd3, 32'h0001_0000);
    reg_read(2'd2, 32'd4);
    reg_write(2'd3, $urandom);
    reg_read(2'd3, 32'd0);

    // Upper index bits are discarded; first-wait-cycle ack.
    start_op(1'b0, 32'h45, 32'd5, 32'd0);
    tick(1);
    table_ack(1'b0, 32'h1234_5678);
    reg_read(2'd1, 32'd5);
    reg_read(2'd0, 32'h1234_5678);

    // Host accesses while busy are dropped and flag overrun.
    start_op(1'b0, 32'h29, 32'd9, 32'd0);
    tick(1);
    host(1'b1, 2'd0, 32'd0);
    host(1'b0, 2'd3, 32'd0);
    table_ack(1'b0, 32'hA5A5_0009);
    reg_read(2'd3, 32'h0000_0004);
    reg_read(2'd0, 32'hA5A5_0009);
    reg_write(2'd3, 32'd0);
    reg_read(2'd3, 32'd0);

    // Reset during WR_WAIT aborts the op without a host ack.
    reg_write(2'd0, 32'h1122_3344);
    start_op(1'b1, 32'd2, 32'd2, 32'h1122_3344);
    tick(2);
    reset = 1'b1;
    tick(1);
    check("abort_wr_req", 32'(wr_req), 32'd0);
    check("abort_reg_ack", 32'(reg_ack), 32'd0);
    check("abort_wr_ip", wr_ip, 32'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    wr_ack = 1'b1;
    tick(1);
    wr_ack = 1'b0;
    tick(2);
    reg_read(2'd0, 32'd0);
    reg_read(2'd1, 32'd0);
    reg_read(2'd2, 32'd0);
    reg_read(2'd3, 32'd0);

    tick(5);
    check("ack_q_drained", 32'(ack_q.size()), 32'd0);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
